alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes and an
// architectural NZCV flag register.
//
// Stage S1 captures a request (operands, opcode, set_flags). When S1 moves
// into S2 ("advance") the result and per-op flags are computed from the S1
// contents and the flag register as it stands, and the flag register is
// updated in the same edge if the request asked for it.
//
// Ports:
//   clk                    rising-edge clock
//   reset                  asynchronous active-high reset
//   in_valid / in_ready    request handshake
//   A, B                   operands (WIDTH bits)
//   cntrl                  opcode: 000 pass B, 001 ADC, 010 add, 011 sub,
//                          100 and, 101 or, 110 xor, 111 SBC
//   set_flags              request updates the flag register on advance
//   out_valid / out_ready  result handshake
//   result                 operation result
//   negative, zero, overflow, carry_out   per-op flags of presented result
//   flag_n, flag_z, flag_c, flag_v        architectural flag register
module alu_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_SBC  = 3'b111;

    // Pipeline and flag state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s1_sf_q, s1_sf_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_n_q, s2_n_d;
    logic             s2_z_q, s2_z_d;
    logic             s2_v_q, s2_v_d;
    logic             s2_c_q, s2_c_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;

    // Combinational helpers
    logic             advance_s;
    logic             accept_s;
    logic             is_arith_s;
    logic             invert_b_s;
    logic             carry_in_s;
    logic [WIDTH-1:0] b_op_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             v_s;

    // S1 may hand its request to S2 when S2 is empty or being drained.
    assign advance_s = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready  = !reset && (!s1_valid_q || advance_s);
    assign accept_s  = in_valid && in_ready;

    // Operand conditioning and the single shared adder.
    always_comb begin
        is_arith_s = 1'b0;
        invert_b_s = 1'b0;
        carry_in_s = 1'b0;
        case (s1_op_q)
            OP_ADC: begin
                is_arith_s = 1'b1;
                carry_in_s = flag_c_q;
            end
            OP_ADD: begin
                is_arith_s = 1'b1;
            end
            OP_SUB: begin
                is_arith_s = 1'b1;
                invert_b_s = 1'b1;
                carry_in_s = 1'b1;
            end
            OP_SBC: begin
                is_arith_s = 1'b1;
                invert_b_s = 1'b1;
                carry_in_s = flag_c_q;
            end
            default: begin
                is_arith_s = 1'b0;
            end
        endcase
        if (invert_b_s) begin
            b_op_s = ~s1_b_q;
        end else begin
            b_op_s = s1_b_q;
        end
        sum_s = {1'b0, s1_a_q} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, carry_in_s};
    end

    // Result selection and per-op carry/overflow.
    always_comb begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (s1_op_q)
            OP_PASS: res_s = s1_b_q;
            OP_AND:  res_s = s1_a_q & s1_b_q;
            OP_OR:   res_s = s1_a_q | s1_b_q;
            OP_XOR:  res_s = s1_a_q ^ s1_b_q;
            default: res_s = sum_s[WIDTH-1:0];
        endcase
        if (is_arith_s) begin
            c_s = sum_s[WIDTH];
            // Signed overflow: both addends share a sign the sum does not.
            v_s = (s1_a_q[WIDTH-1] == b_op_s[WIDTH-1]) &&
                  (sum_s[WIDTH-1] != s1_a_q[WIDTH-1]);
        end else begin
            c_s = 1'b0;
            v_s = 1'b0;
        end
    end

    // Next-state for both pipeline stages and the flag register.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s1_sf_d     = s1_sf_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_n_d      = s2_n_q;
        s2_z_d      = s2_z_q;
        s2_v_d      = s2_v_q;
        s2_c_d      = s2_c_q;
        flag_n_d    = flag_n_q;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        flag_v_d    = flag_v_q;

        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_a_d     = A;
            s1_b_d     = B;
            s1_op_d    = cntrl;
            s1_sf_d    = set_flags;
        end else if (advance_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (advance_s) begin
            s2_valid_d  = 1'b1;
            s2_result_d = res_s;
            s2_n_d      = res_s[WIDTH-1];
            s2_z_d      = (res_s == {WIDTH{1'b0}});
            s2_v_d      = v_s;
            s2_c_d      = c_s;
            if (s1_sf_q) begin
                flag_n_d = res_s[WIDTH-1];
                flag_z_d = (res_s == {WIDTH{1'b0}});
                // Logic and pass ops leave C and V untouched.
                if (is_arith_s) begin
                    flag_c_d = c_s;
                    flag_v_d = v_s;
                end else begin
                    flag_c_d = flag_c_q;
                    flag_v_d = flag_v_q;
                end
            end else begin
                flag_n_d = flag_n_q;
            end
        end else if (s2_valid_q && out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= {WIDTH{1'b0}};
            s1_b_q      <= {WIDTH{1'b0}};
            s1_op_q     <= 3'b000;
            s1_sf_q     <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= {WIDTH{1'b0}};
            s2_n_q      <= 1'b0;
            s2_z_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_c_q      <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_sf_q     <= s1_sf_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_n_q      <= s2_n_d;
            s2_z_q      <= s2_z_d;
            s2_v_q      <= s2_v_d;
            s2_c_q      <= s2_c_d;
            flag_n_q    <= flag_n_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
            flag_v_q    <= flag_v_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_result_q;
    assign negative  = s2_n_q;
    assign zero      = s2_z_q;
    assign overflow  = s2_v_q;
    assign carry_out = s2_c_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed + light random bench for alu_pipe (WIDTH=64 main
// instance, WIDTH=8 instance for narrow-width corner cases). Expected
// results come from a reference model and are queued on acceptance,
// then compared when the DUT hands the result out.
module tb_alu_pipe;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_SBC  = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a_i = 64'd0;
    logic [63:0] b_i = 64'd0;
    logic [2:0]  op_i = 3'b000;
    logic        sf_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        negative, zero, overflow, carry_out;
    logic        flag_n, flag_z, flag_c, flag_v;

    logic        v8 = 1'b0;
    logic        rdy8;
    logic [7:0]  a8 = 8'd0;
    logic [7:0]  b8 = 8'd0;
    logic [2:0]  op8 = 3'b010;
    logic        ov8;
    logic [7:0]  res8;
    logic        n8, z8, v8f, c8;
    logic        fn8, fz8, fc8, fv8;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic acc = 1'b0;
    logic [67:0] sb[$];
    logic mn = 1'b0, mz = 1'b0, mc = 1'b0, mv = 1'b0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_i), .B(b_i), .cntrl(op_i), .set_flags(sf_i),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
        .A(a8), .B(b8), .cntrl(op8), .set_flags(1'b0),
        .out_valid(ov8), .out_ready(1'b1), .result(res8),
        .negative(n8), .zero(z8), .overflow(v8f), .carry_out(c8),
        .flag_n(fn8), .flag_z(fz8), .flag_c(fc8), .flag_v(fv8)
    );

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {result, N, Z, V, C}, updates model flags.
    function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] op, input logic sf);
        logic [64:0] s;
        logic [63:0] r;
        logic [63:0] bb;
        logic        arith;
        logic        c;
        logic        v;
        arith = 1'b1;
        bb = b;
        s = 65'd0;
        case (op)
            OP_ADC: s = {1'b0, a} + {1'b0, b} + {64'd0, mc};
            OP_ADD: s = {1'b0, a} + {1'b0, b};
            OP_SUB: begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + 65'd1; end
            OP_SBC: begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + {64'd0, mc}; end
            default: arith = 1'b0;
        endcase
        case (op)
            OP_PASS: r = b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = s[63:0];
        endcase
        c = arith ? s[64] : 1'b0;
        v = arith ? ((a[63] & bb[63] & ~r[63]) | (~a[63] & ~bb[63] & r[63])) : 1'b0;
        if (sf) begin
            mn = r[63];
            mz = (r == 64'd0);
            if (arith) begin
                mc = c;
                mv = v;
            end
        end
        return {r, r[63], (r == 64'd0), v, c};
    endfunction

    // One clock: compare any retiring result, note acceptance, queue expectation.
    task automatic step();
        logic [67:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            pops++;
            check("sb_nonempty", {67'd0, (sb.size() != 0)}, 68'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("result", {result, negative, zero, overflow, carry_out}, e);
            end
        end
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) sb.push_back(model(a_i, b_i, op_i, sf_i));
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] op, input logic sf);
        in_valid = 1'b1;
        a_i = a;
        b_i = b;
        op_i = op;
        sf_i = sf;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        check("drain_bound", {67'd0, (n < 50)}, 68'd1);
    endtask

    initial begin
        logic [67:0] held;
        logic [3:0]  fsave;
        int p0;
        int n;

        // Reset state
        #12;
        check("rst_in_ready", {67'd0, in_ready}, 68'd0);
        check("rst_outputs", {out_valid, result, negative, zero, overflow, carry_out},
              68'd0);
        check("rst_flags", {64'd0, flag_n, flag_z, flag_c, flag_v}, 68'd0);

        // First request on first edge after reset release; 1-cycle latency
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        drive(64'd1, 64'd1, OP_ADD, 1'b0);
        #1;
        check("in_ready_after_rst", {67'd0, in_ready}, 68'd1);
        step();
        check("first_accept", {67'd0, acc}, 68'd1);
        in_valid = 1'b0;
        step();
        check("latency_out_valid", {67'd0, out_valid}, 68'd1);
        check("add_1_1", {result, negative, zero, overflow, carry_out}, {64'd2, 4'b0000});
        drain();

        // sub 5-5 sets Z and C, ADC then sees C=1
        drive(64'd5, 64'd5, OP_SUB, 1'b1);
        step();
        drive(64'd0, 64'd0, OP_ADC, 1'b0);
        step();
        drain();
        check("flags_after_sub", {64'd0, flag_n, flag_z, flag_c, flag_v}, {64'd0, 4'b0110});
        check("flags_model", {64'd0, flag_n, flag_z, flag_c, flag_v}, {64'd0, mn, mz, mc, mv});

        // Narrow width corner cases on the 8-bit instance
        v8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; op8 = OP_ADD;
        step();
        a8 = 8'hFF;
        step();
        v8 = 1'b0;
        check("w8_7f_plus_1", {59'd0, ov8, res8, n8, z8, v8f, c8}, {59'd0, 1'b1, 8'h80, 4'b1010});
        step();
        check("w8_ff_plus_1", {59'd0, ov8, res8, n8, z8, v8f, c8}, {59'd0, 1'b1, 8'h00, 4'b0101});

        // Backpressure: 2 accepts fill the pipe, result holds, then 3 retire back to back
        out_ready = 1'b0;
        drive(64'd10, 64'd20, OP_ADD, 1'b0);
        step();
        drive(64'hF0F0, 64'h0FF0, OP_XOR, 1'b0);
        step();
        check("bp_in_ready_low", {67'd0, in_ready}, 68'd0);
        drive(64'h1234, 64'h8000_0000_0000_0000, OP_OR, 1'b0);
        held = {result, negative, zero, overflow, carry_out};
        step();
        step();
        check("bp_hold", {result, negative, zero, overflow, carry_out}, held);
        check("bp_hold_valid", {67'd0, out_valid}, 68'd1);
        p0 = pops;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("bp_consecutive", pops - p0, 68'd3);
        drain();

        // Flag hold: logic op keeps C, pass without set_flags changes nothing
        drive(64'd3, 64'd1, OP_SUB, 1'b1);
        step();
        drive(64'hF0, 64'h0F, OP_AND, 1'b1);
        step();
        drain();
        check("and_z_c_hold", {66'd0, flag_z, flag_c}, 68'd3);
        fsave = {flag_n, flag_z, flag_c, flag_v};
        drive(64'd5, 64'h8000_0000_0000_0005, OP_PASS, 1'b0);
        step();
        drain();
        check("pass_no_flags", {64'd0, flag_n, flag_z, flag_c, flag_v}, {64'd0, fsave});

        // Random traffic with random backpressure
        for (int i = 0; i < 24; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom},
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (i % 5 == 0) b_i = ~a_i;
            n = 0;
            acc = 1'b0;
            while (!acc && n < 20) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
                n++;
            end
            check("rand_accept_bound", {67'd0, acc}, 68'd1);
        end
        drain();
        check("rand_flags", {64'd0, flag_n, flag_z, flag_c, flag_v}, {64'd0, mn, mz, mc, mv});

        // Reset with both stages full
        out_ready = 1'b0;
        drive(64'd1, 64'd2, OP_SUB, 1'b1);
        step();
        drive(64'd7, 64'd8, OP_ADD, 1'b0);
        step();
        in_valid = 1'b0;
        check("pre_rst_full", {66'd0, out_valid, flag_n}, 68'd3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_outputs", {out_valid, result, negative, zero, overflow, carry_out},
              68'd0);
        check("mid_rst_flags", {63'd0, in_ready, flag_n, flag_z, flag_c, flag_v}, 68'd0);
        sb.delete();
        mn = 1'b0; mz = 1'b0; mc = 1'b0; mv = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 5; i++) step();
        check("no_stale_result", {67'd0, out_valid}, 68'd0);
        check("no_stale_pops", pops - p0, 68'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
